// File: rtl/hex_entry_pkg.sv
// Shared state encoding and defaults for the hex operand entry stage.
package hex_entry_pkg;

    localparam int unsigned DIGITS_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT  = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_FULL  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/hex_digit_entry_mask.sv
// Thermometer mask from digit count: bit i set when i < count.
module digit_mask_gen #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic [CNT_W-1:0]  count,
    output logic [DIGITS-1:0] mask_c
);

    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            mask_c[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/hex_digit_entry.sv
// Operator hex operand entry with valid/ready handoff to the converter.
// Optional macro HEX_ENTRY_DEC_ONLY_EN restricts digits to 0..9 and adds digit_err.
module hex_digit_entry
    import hex_entry_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            switches,
    input  logic                  enter_pulse,
    input  logic                  backspace_pulse,
    input  logic                  clear_pulse,
    input  logic                  confirm_pulse,
    output logic [4*DIGITS-1:0]   numb,
    output logic [DIGITS-1:0]     mask,
    output logic [CNT_W-1:0]      count,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow_err,
    output logic                  locked
`ifdef HEX_ENTRY_DEC_ONLY_EN
    ,
    output logic                  digit_err
`endif
);

    localparam int unsigned NW = 4 * DIGITS;

    state_t              state, state_d;
    logic [NW-1:0]       numb_d, out_data_d;
    logic [CNT_W-1:0]    count_d;
    logic                out_valid_d, overflow_d, locked_d, digit_err_d;
    logic                digit_ok;
    logic [DIGITS-1:0]   mask_c;

`ifdef HEX_ENTRY_DEC_ONLY_EN
    assign digit_ok = (switches <= 4'd9);
`else
    assign digit_ok = 1'b1;
`endif

    // Mask tracks the next count so it lands in the same cycle as count.
    digit_mask_gen #(
        .DIGITS (DIGITS),
        .CNT_W  (CNT_W)
    ) u_mask (
        .count  (count_d),
        .mask_c (mask_c)
    );

    // Next-state and next-output decode; only the highest-priority strobe acts.
    always_comb begin
        state_d     = state;
        numb_d      = numb;
        count_d     = count;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        overflow_d  = 1'b0;
        digit_err_d = 1'b0;

        if (clear_pulse) begin
            numb_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_ENTRY: begin
                    if (confirm_pulse) begin
                        if (state == S_ENTRY) begin
                            out_data_d  = numb;
                            out_valid_d = 1'b1;
                            state_d     = S_HOLD;
                        end
                    end else if (backspace_pulse) begin
                        if (state == S_ENTRY) begin
                            numb_d  = numb >> 4;
                            count_d = count - CNT_W'(1);
                            if (count == CNT_W'(1)) state_d = S_IDLE;
                        end
                    end else if (enter_pulse) begin
                        if (digit_ok) begin
                            numb_d  = {numb[NW-5:0], switches};
                            count_d = count + CNT_W'(1);
                            state_d = (count == CNT_W'(DIGITS - 1)) ? S_FULL : S_ENTRY;
                        end else begin
                            digit_err_d = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (confirm_pulse) begin
                        out_data_d  = numb;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else if (backspace_pulse) begin
                        numb_d  = numb >> 4;
                        count_d = count - CNT_W'(1);
                        state_d = S_ENTRY;
                    end else if (enter_pulse) begin
                        overflow_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        locked_d = (state_d == S_HOLD) || (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            numb         <= '0;
            count        <= '0;
            mask         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            overflow_err <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_d;
            numb         <= numb_d;
            count        <= count_d;
            mask         <= mask_c;
            out_data     <= out_data_d;
            out_valid    <= out_valid_d;
            overflow_err <= overflow_d;
            locked       <= locked_d;
        end
    end

`ifdef HEX_ENTRY_DEC_ONLY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) digit_err <= 1'b0;
        else        digit_err <= digit_err_d;
    end
`else
    logic unused_digit_err;
    assign unused_digit_err = digit_err_d;
`endif

endmodule

// File: tb/tb_hex_digit_entry.sv
// Directed self-checking bench for hex_digit_entry (DIGITS=8).
module tb_hex_digit_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  switches = '0;
    logic        enter_pulse = 1'b0, backspace_pulse = 1'b0;
    logic        clear_pulse = 1'b0, confirm_pulse = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] numb, out_data;
    logic [7:0]  mask;
    logic [3:0]  count;
    logic        out_valid, overflow_err, locked;
`ifdef HEX_ENTRY_DEC_ONLY_EN
    logic        digit_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_digit_entry dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .switches        (switches),
        .enter_pulse     (enter_pulse),
        .backspace_pulse (backspace_pulse),
        .clear_pulse     (clear_pulse),
        .confirm_pulse   (confirm_pulse),
        .numb            (numb),
        .mask            (mask),
        .count           (count),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .overflow_err    (overflow_err),
        .locked          (locked)
`ifdef HEX_ENTRY_DEC_ONLY_EN
        ,
        .digit_err       (digit_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes; returns 1 time unit after the sampling edge.
    task automatic step(input logic e, input logic b, input logic c, input logic cf,
                        input logic r, input logic [3:0] sw);
        enter_pulse = e; backspace_pulse = b; clear_pulse = c;
        confirm_pulse = cf; out_ready = r; switches = sw;
        @(posedge clk);
        #1;
        enter_pulse = 0; backspace_pulse = 0; clear_pulse = 0;
        confirm_pulse = 0; out_ready = 0; switches = '0;
    endtask

    task automatic enter(input logic [3:0] sw);
        step(1, 0, 0, 0, 0, sw);
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        check("rst_numb", numb, 0);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        #5 rst_n = 1'b1;

        // Reset mid-entry
        enter(4'h1); enter(4'h2); enter(4'h3);
        check("t1_numb", numb, 32'h123);
        check("t1_mask", 32'(mask), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("t1_arst_numb", numb, 0);
        check("t1_arst_count", 32'(count), 0);
        check("t1_arst_mask", 32'(mask), 0);
        check("t1_arst_valid", 32'(out_valid), 0);
        #2 rst_n = 1'b1;

        // Fill and overflow
        for (int i = 1; i <= 8; i++) enter(4'(i));
        check("t2_numb", numb, 32'h12345678);
        check("t2_mask", 32'(mask), 32'hFF);
        check("t2_count", 32'(count), 8);
        enter(4'h9);
        check("t2_ovf", 32'(overflow_err), 1);
        check("t2_ovf_numb", numb, 32'h12345678);
        step(0, 0, 0, 0, 0, 4'h0);
        check("t2_ovf_clr", 32'(overflow_err), 0);
        step(0, 1, 0, 0, 0, 4'h0);
        check("t2_bs_numb", numb, 32'h1234567);
        check("t2_bs_mask", 32'(mask), 32'h7F);
        step(0, 0, 1, 0, 0, 4'h0);
        check("t2_clr_count", 32'(count), 0);

        // Backspace
        enter(4'hA); enter(4'hB); enter(4'hC);
        check("t3_abc", numb, 32'hABC);
        step(0, 1, 0, 0, 0, 4'h0);
        check("t3_ab", numb, 32'hAB);
        step(0, 1, 0, 0, 0, 4'h0);
        check("t3_a", numb, 32'hA);
        step(0, 1, 0, 0, 0, 4'h0);
        check("t3_empty", numb, 0);
        check("t3_count0", 32'(count), 0);
        check("t3_mask0", 32'(mask), 0);
        step(0, 1, 0, 0, 0, 4'h0);
        check("t3_bs_idle", 32'(count), 0);
        step(0, 0, 0, 1, 0, 4'h0);
        check("t3_cf_idle", 32'(out_valid), 0);

        // Handshake
        enter(4'h3); enter(4'hC);
        step(0, 0, 0, 1, 0, 4'h0);
        check("t4_data", out_data, 32'h3C);
        check("t4_locked", 32'(locked), 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 4'h0);
            check("t4_hold_valid", 32'(out_valid), 1);
        end
        step(0, 0, 0, 0, 1, 4'h0);
        check("t4_accept", 32'(out_valid), 0);
        check("t4_done_lock", 32'(locked), 1);
        enter(4'h5);
        check("t4_done_numb", numb, 32'h3C);
        check("t4_done_cnt", 32'(count), 2);
        step(0, 0, 1, 0, 0, 4'h0);
        check("t4_unlock", 32'(locked), 0);

        // Simultaneous strobes
        enter(4'h1); enter(4'h2);
        step(1, 0, 0, 1, 0, 4'h7);
        check("t5_cf_data", out_data, 32'h12);
        check("t5_cf_cnt", 32'(count), 2);
        check("t5_cf_valid", 32'(out_valid), 1);
        step(0, 0, 1, 0, 1, 4'h0);
        check("t5_clr_valid", 32'(out_valid), 0);
        check("t5_clr_lock", 32'(locked), 0);
        check("t5_clr_cnt", 32'(count), 0);

        // Digit filter configuration
        enter(4'hB);
`ifdef HEX_ENTRY_DEC_ONLY_EN
        check("t6_derr", 32'(digit_err), 1);
        check("t6_rej_cnt", 32'(count), 0);
        step(0, 0, 0, 0, 0, 4'h0);
        check("t6_derr_clr", 32'(digit_err), 0);
`else
        check("t6_acc_cnt", 32'(count), 1);
        check("t6_acc_numb", numb, 32'hB);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
